uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmit engine between NREQ byte requesters.
- Runs entirely in the bclk domain and sits between the requesters and the engine's start/data/busy interface.
- Grants one byte at a time, issues a single start pulse to the engine, and tracks the engine's busy window.
- Returns an ack to the winning requester and flags an engine that never goes busy.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data byte width.
- IW, $clog2(NREQ), width of the grant index (derived, not overridden).

Ports:
- bclk  in  1  bit clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = new grants allowed; 0 = finish the current byte, then stall.
- req  in  NREQ  per-requester request; held until the matching ack.
- req_data  in  NREQ*DW  byte for requester i at bits [i*DW +: DW].
- req_ack  out  NREQ  one-cycle pulse: byte accepted and handed to the engine.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_data  out  DW  latched byte; stable from the start pulse until the engine drops busy.
- eng_busy  in  1  engine transmitting.
- gnt_valid  out  1  a transfer is in flight (state != IDLE).
- gnt_idx  out  IW  index of the current or last winner.
- err  out  1  sticky: engine failed to assert busy.
- err_clr  in  1  clears err.

Behaviour:
- State machine:
  - IDLE: when enable && |req && !eng_busy, latch the winner index and its byte, then go to START.
  - START: eng_start=1 and req_ack[winner]=1 in the same cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: if eng_busy, go to WAIT_DONE. Otherwise increment wcnt; when wcnt reaches BUSY_WAIT_MAX (3), set err and go to IDLE.
  - WAIT_DONE: when !eng_busy, update ptr to the winner and go to IDLE.
- Round-robin: search starts at ptr+1 and wraps modulo NREQ; the first set req bit wins. ptr changes only on completion or timeout.
- Latency: req seen in IDLE at cycle n gives eng_start and ack at n+1. The next grant is possible no earlier than the cycle after eng_busy falls.
- All outputs are registered. eng_start and req_ack are exactly one cycle wide.
- Withdrawal: a requester may drop req before it is latched in IDLE. Once latched, the byte is committed and the ack is still issued.
- After ack, a requester may change req_data or req on the next cycle.
- enable falling mid-transfer does not abort the transfer; the FSM completes and then holds in IDLE.
- eng_busy high while in IDLE (engine still draining): no grant until it falls.
- err_clr and a timeout in the same cycle: the set wins.
- Reset (asynchronous, any state) sets:
  - state = IDLE, ptr = NREQ-1 (requester 0 has first priority), wcnt = 0
  - req_ack = 0, eng_start = 0, eng_data = 0, gnt_idx = 0, gnt_valid = 0, err = 0
- The engine shares the same reset, so no partial frame survives a reset.

Optional Feature:
- Macro UART_ARB_LOCK_EN enables packet lock.
- With the macro:
  - Adds input req_last (NREQ wide), sampled with req_data.
  - If the latched byte has last=0, only the same requester may win the next grant, even if others request.
  - Lock releases after a byte with last=1 completes, on a timeout, or on reset.
  - Output locked (1 bit) shows lock status; reset value 0.
- Without the macro: no req_last or locked ports, and every byte is arbitrated independently.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3 (2-bit)
  - BUSY_WAIT_MAX=3
  - wcnt width 2
- Sub-module rr_pick: purely combinational NREQ-wide round-robin picker. Inputs are req and ptr; outputs are found and idx.

Test Plan:
- Single request: after reset, req=4'b0100, data 8'hA5 → ack[2] and eng_start at +1 cycle, eng_data=8'hA5, gnt_idx=2; engine busy 11 cycles, then IDLE.
- Fairness: req=4'b1111 held, each requester reloading after its ack → grant order 0,1,2,3,0; no requester is granted twice while another waits.
- Stall: enable=0 with req=4'b0001 → no eng_start for 50 cycles. Raise enable → start pulse 1 cycle later.
- Timeout: eng_busy stuck at 0 after start → err=1 on the 3rd WAIT_BUSY cycle, FSM back in IDLE, ptr advanced. err_clr=1 → err=0 next cycle.
- Reset mid-transfer: assert reset during WAIT_DONE → all outputs 0 immediately. After release, req=4'b0011 → requester 0 is granted first.
- Lock (UART_ARB_LOCK_EN): requester 1 sends 3 bytes with last=0,0,1 while requester 0 requests continuously → bytes 1,1,1 are sent, then requester 0 is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The optional packet-lock feature is selected by the UART_ARB_LOCK_EN macro
// in uart_tx_arbiter.sv; nothing in this package depends on it.
package uart_arb_pkg;

  // Arbiter FSM encoding; the values are visible on the dbg_state output.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Number of WAIT_BUSY cycles the engine gets to raise busy before the
  // arbiter gives up and flags err.
  localparam int BUSY_WAIT_MAX = 3;

  // Width of the busy-wait counter; must hold BUSY_WAIT_MAX.
  localparam int WCNT_W = 2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The search starts one position after ptr and wraps modulo NREQ; the first
// set request bit found wins. found is low when no request is set.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] pos;

  // Scan from the farthest candidate to the nearest so that the nearest
  // set bit after ptr is the last one written, and therefore the winner.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = IW'((int'(ptr) + k) % NREQ);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine between NREQ byte
// requesters. One byte per grant: latch winner and byte, pulse eng_start and
// the winner's req_ack together, then track the engine busy window.
// An engine that never raises busy within BUSY_WAIT_MAX cycles sets the
// sticky err flag and the arbiter moves on.
//
// Handshake: a requester holds req (and its byte) until it sees its req_ack
// pulse; the byte is committed once latched in IDLE. The engine side is a
// start pulse with eng_data held stable until eng_busy drops.
//
// Optional macro UART_ARB_LOCK_EN: adds req_last/locked. While the last
// latched byte had last=0, only that requester may win the next grant; the
// lock releases when a byte with last=1 is latched, on timeout, or on reset.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              bclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic              eng_start,
  output logic [DW-1:0]     eng_data,
  input  logic              eng_busy,
  output logic              gnt_valid,
  output logic [IW-1:0]     gnt_idx,
  output logic              err,
  input  logic              err_clr,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_last,
  output logic              locked,
`endif
  output state_t            dbg_state
);

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [IW-1:0]       gnt_idx_q, gnt_idx_d;
  logic [DW-1:0]       eng_data_q, eng_data_d;
  logic                eng_start_q, eng_start_d;
  logic [NREQ-1:0]     req_ack_q, req_ack_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                err_q, err_d;
`ifdef UART_ARB_LOCK_EN
  logic                locked_q, locked_d;
`endif

  logic [NREQ-1:0]     pick_req;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;

  // Requests presented to the picker; a held lock masks all but the owner.
  always_comb begin
`ifdef UART_ARB_LOCK_EN
    pick_req = locked_q ? (req & (NREQ'(1) << gnt_idx_q)) : req;
`else
    pick_req = req;
`endif
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wcnt_d      = wcnt_q;
    gnt_idx_d   = gnt_idx_q;
    eng_data_d  = eng_data_q;
    eng_start_d = 1'b0;
    req_ack_d   = '0;
    // A timeout below overrides the clear, so a set in the same cycle wins.
    err_d       = err_q & ~err_clr;
`ifdef UART_ARB_LOCK_EN
    locked_d    = locked_q;
`endif

    unique case (state_q)
      IDLE: begin
        // No grant while the engine is still draining a previous frame.
        if (enable && pick_found && !eng_busy) begin
          gnt_idx_d            = pick_idx;
          eng_data_d           = req_data[int'(pick_idx)*DW +: DW];
          eng_start_d          = 1'b1;
          req_ack_d[pick_idx]  = 1'b1;
          wcnt_d               = '0;
          state_d              = START;
`ifdef UART_ARB_LOCK_EN
          locked_d             = ~req_last[pick_idx];
`endif
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (eng_busy) begin
          wcnt_d  = '0;
          state_d = WAIT_DONE;
        end else if (wcnt_q == WCNT_W'(BUSY_WAIT_MAX - 1)) begin
          // The increment would reach BUSY_WAIT_MAX: give up on this byte.
          wcnt_d  = '0;
          err_d   = 1'b1;
          ptr_d   = gnt_idx_q;
          state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
          locked_d = 1'b0;
`endif
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!eng_busy) begin
          ptr_d   = gnt_idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_valid_d = (state_d != IDLE);
  end

  // All FSM state and registered outputs; asynchronous active-high reset.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      wcnt_q      <= '0;
      gnt_idx_q   <= '0;
      eng_data_q  <= '0;
      eng_start_q <= 1'b0;
      req_ack_q   <= '0;
      gnt_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      locked_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wcnt_q      <= wcnt_d;
      gnt_idx_q   <= gnt_idx_d;
      eng_data_q  <= eng_data_d;
      eng_start_q <= eng_start_d;
      req_ack_q   <= req_ack_d;
      gnt_valid_q <= gnt_valid_d;
      err_q       <= err_d;
`ifdef UART_ARB_LOCK_EN
      locked_q    <= locked_d;
`endif
    end
  end

  assign req_ack   = req_ack_q;
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign err       = err_q;
  assign dbg_state = state_q;
`ifdef UART_ARB_LOCK_EN
  assign locked    = locked_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, DW=8) with a small engine
// model. Define UART_ARB_LOCK_EN to build and exercise the packet-lock ports.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;
  localparam int BUSY_LEN = 11;

  // ---------------------------------------------------------------- clock/reset
  logic bclk = 1'b0;
  logic reset = 1'b1;
  always #5 bclk = ~bclk;

  logic              enable = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic              eng_start;
  logic [DW-1:0]     eng_data;
  logic              eng_busy;
  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;
  logic              err;
  logic              err_clr = 1'b0;
  state_t            dbg_state;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_last = '1;
  logic              locked;
`endif

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .eng_start (eng_start),
    .eng_data  (eng_data),
    .eng_busy  (eng_busy),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .err       (err),
    .err_clr   (err_clr),
`ifdef UART_ARB_LOCK_EN
    .req_last  (req_last),
    .locked    (locked),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- engine model
  // Raises busy for BUSY_LEN cycles after a start pulse; eng_dead makes it
  // ignore starts, force_busy holds busy high as if still draining.
  int   busy_cnt = 0;
  logic busy_r = 1'b0;
  logic eng_dead = 1'b0;
  logic force_busy = 1'b0;
  assign eng_busy = busy_r | force_busy;

  always @(negedge bclk or posedge reset) begin
    if (reset) begin
      busy_cnt = 0;
    end else if (eng_start && !eng_dead) begin
      busy_cnt = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    busy_r = (busy_cnt > 0);
  end

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge bclk);
      n++;
    end while (!eng_start && n < 100);
    if (!eng_start) chk({tag, "_start_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (gnt_valid && n < 100) begin
      @(negedge bclk);
      n++;
    end
    if (gnt_valid) chk({tag, "_idle_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;

    // Reset values
    repeat (3) @(negedge bclk);
    chk("rst_ack",   32'(req_ack),   32'h0);
    chk("rst_start", 32'(eng_start), 32'h0);
    chk("rst_data",  32'(eng_data),  32'h0);
    chk("rst_idx",   32'(gnt_idx),   32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_err",   32'(err),       32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;

    // Single request: start and ack one cycle after req is seen in IDLE
    @(negedge bclk);
    enable = 1'b1;
    set_data(2, 8'hA5);
    req = 4'b0100;
    @(negedge bclk);
    chk("single_start", 32'(eng_start), 32'h1);
    chk("single_ack",   32'(req_ack),   32'h4);
    chk("single_data",  32'(eng_data),  32'hA5);
    chk("single_idx",   32'(gnt_idx),   32'h2);
    req = 4'b0000;
    set_data(2, 8'h00);
    @(negedge bclk);
    chk("single_pulse_start", 32'(eng_start), 32'h0);
    chk("single_pulse_ack",   32'(req_ack),   32'h0);
    // Busy spans 11 cycles from the start cycle; IDLE is seen 12 cycles on.
    n = 1;
    while (gnt_valid && n < 100) begin
      @(negedge bclk);
      n++;
    end
    chk("single_len",       32'(n),        32'd12);
    chk("single_data_hold", 32'(eng_data), 32'hA5);

    // Fairness: all four requesting, reset restores requester 0 as first
    reset = 1'b1;
    @(negedge bclk);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'(8'h10 + i));
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    req = 4'b1111;
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      wait_start("fair");
      chk("fair_idx",  32'(gnt_idx),  e);
      chk("fair_data", 32'(eng_data), 32'h10 + e);
    end
    req = 4'b0000;
    wait_idle("fair");

    // Stall: enable low blocks grants; start one cycle after enable rises
    enable = 1'b0;
    req = 4'b0001;
    n = 0;
    repeat (50) begin
      @(negedge bclk);
      if (eng_start) n++;
    end
    chk("stall_starts", 32'(n), 32'd0);
    enable = 1'b1;
    @(negedge bclk);
    chk("stall_release_start", 32'(eng_start), 32'h1);
    chk("stall_release_ack",   32'(req_ack),   32'h1);
    req = 4'b0000;
    wait_idle("stall");

    // Engine still busy while IDLE: no grant until busy falls (ptr=0 -> 2)
    force_busy = 1'b1;
    req = 4'b0100;
    n = 0;
    repeat (5) begin
      @(negedge bclk);
      if (eng_start) n++;
    end
    chk("drain_starts", 32'(n), 32'd0);
    force_busy = 1'b0;
    @(negedge bclk);
    chk("drain_release_start", 32'(eng_start), 32'h1);
    chk("drain_release_idx",   32'(gnt_idx),   32'h2);
    req = 4'b0000;
    wait_idle("drain");

    // Timeout: engine never goes busy; err after 3rd WAIT_BUSY cycle (ptr=2 -> 1)
    eng_dead = 1'b1;
    req = 4'b0010;
    wait_start("tmo");
    req = 4'b0000;
    repeat (3) @(negedge bclk);
    chk("tmo_err_early", 32'(err),       32'h0);
    chk("tmo_valid_early", 32'(gnt_valid), 32'h1);
    @(negedge bclk);
    chk("tmo_err",   32'(err),       32'h1);
    chk("tmo_valid", 32'(gnt_valid), 32'h0);
    chk("tmo_state", 32'(dbg_state), 32'(IDLE));
    err_clr = 1'b1;
    @(negedge bclk);
    chk("tmo_clr", 32'(err), 32'h0);

    // Timeout with err_clr held: the set wins, then the clear takes it (ptr=1 -> 2)
    req = 4'b0100;
    wait_start("tmo2");
    req = 4'b0000;
    repeat (4) @(negedge bclk);
    chk("tmo2_set_wins", 32'(err), 32'h1);
    @(negedge bclk);
    chk("tmo2_clr", 32'(err), 32'h0);
    err_clr = 1'b0;
    eng_dead = 1'b0;

    // ptr advanced to 2 on timeout, so 0 beats 1 next
    set_data(0, 8'h5A);
    req = 4'b0011;
    wait_start("ptr");
    chk("ptr_idx", 32'(gnt_idx), 32'h0);
    chk("ptr_ack", 32'(req_ack), 32'h1);
    req = 4'b0010;
    repeat (4) @(negedge bclk);
    chk("mid_state", 32'(dbg_state), 32'(WAIT_DONE));

    // Reset mid-transfer: outputs clear immediately
    reset = 1'b1;
    #1;
    chk("mrst_data",  32'(eng_data),  32'h0);
    chk("mrst_valid", 32'(gnt_valid), 32'h0);
    chk("mrst_state", 32'(dbg_state), 32'(IDLE));
    chk("mrst_busy",  32'(eng_busy),  32'h0);
    req = 4'b0011;
    @(negedge bclk);
    reset = 1'b0;
    @(negedge bclk);
    chk("mrst_start", 32'(eng_start), 32'h1);
    chk("mrst_ack",   32'(req_ack),   32'h1);
    chk("mrst_idx",   32'(gnt_idx),   32'h0);
    req = 4'b0000;
    wait_idle("mrst");

`ifdef UART_ARB_LOCK_EN
    // Lock: requester 1 sends 3 bytes (last=0,0,1) while 0 keeps requesting
    set_data(1, 8'h31);
    req_last = 4'b1101;
    req = 4'b0010;
    wait_start("lock1");
    chk("lock1_idx",    32'(gnt_idx),  32'h1);
    chk("lock1_data",   32'(eng_data), 32'h31);
    chk("lock1_locked", 32'(locked),   32'h1);
    set_data(1, 8'h32);
    set_data(0, 8'h40);
    req = 4'b0011;
    wait_start("lock2");
    chk("lock2_idx",  32'(gnt_idx),  32'h1);
    chk("lock2_data", 32'(eng_data), 32'h32);
    set_data(1, 8'h33);
    req_last = 4'b1111;
    wait_start("lock3");
    chk("lock3_idx",    32'(gnt_idx),  32'h1);
    chk("lock3_data",   32'(eng_data), 32'h33);
    chk("lock3_locked", 32'(locked),   32'h0);
    req = 4'b0001;
    wait_start("lock4");
    chk("lock4_idx",  32'(gnt_idx),  32'h0);
    chk("lock4_data", 32'(eng_data), 32'h40);
    req = 4'b0000;
    wait_idle("lock");
`endif

    // ---------------------------------------------------------------- report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
